// File: rtl/seg_display_driver.sv
// N-digit seven-segment driver: sequential double-dabble BIN->BCD plus time-multiplexed scan.
// Optional leading-zero blanking when SEG_DISPLAY_LZB_EN is defined.
module seg_display_driver #(
    parameter int DIGITS      = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  bin_in,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DIGITS-1:0] control_pins,
    output logic [6:0]        display_pins
);
    localparam int NIB   = DIGITS + 1;
    localparam int BCD_W = 4 * NIB;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                state;
    logic [BIN_W-1:0]      shift_bin;
    logic [BCD_W-1:0]      scratch;
    logic [CNT_W-1:0]      iter;
    logic [4*DIGITS-1:0]   disp_bcd;
    logic [BCD_W-1:0]      adj;
    logic [BCD_W-1:0]      next_scratch;
    logic [BIN_W-1:0]      next_bin;

    logic [PRE_W-1:0]      presc;
    logic [IDX_W-1:0]      idx;
    logic                  lit;
    logic                  wrap;
    logic [6:0]            seg_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    // One double-dabble iteration: correct every nibble, then shift {bcd, bin}.
    always_comb begin
        adj = scratch;
        for (int unsigned n = 0; n < NIB; n++) begin
            if (adj[4*n +: 4] >= 4'd5)
                adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
        end
        {next_scratch, next_bin} = {adj, shift_bin} << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_bin <= '0;
            scratch   <= '0;
            iter      <= '0;
            disp_bcd  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shift_bin <= bin_in;
                        scratch   <= '0;
                        iter      <= '0;
                        busy      <= 1'b1;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    scratch   <= next_scratch;
                    shift_bin <= next_bin;
                    iter      <= iter + 1'b1;
                    if (iter == CNT_W'(BIN_W - 1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (scratch[BCD_W-1 -: 4] != 4'd0) begin
                        overflow <= 1'b1;
                    end else begin
                        overflow <= 1'b0;
                        disp_bcd <= scratch[4*DIGITS-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wrap = (presc == PRE_W'(REFRESH_DIV - 1));

    always_comb begin
        seg_next = decode(disp_bcd[4*idx +: 4]);
`ifdef SEG_DISPLAY_LZB_EN
        begin
            logic nz_above;
            nz_above = 1'b0;
            for (int unsigned n = 0; n < DIGITS; n++) begin
                if (IDX_W'(n) >= idx && disp_bcd[4*n +: 4] != 4'd0)
                    nz_above = 1'b1;
            end
            if (idx != '0 && !nz_above)
                seg_next = 7'h7F;
        end
`endif
        if (overflow)
            seg_next = 7'h3F;
    end

    // The first wrap only enables the pins; the index starts advancing from the next wrap,
    // so digit 0 is the first one lit after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            idx          <= '0;
            lit          <= 1'b0;
            control_pins <= '1;
            display_pins <= 7'h7F;
        end else begin
            if (wrap) begin
                presc <= '0;
                lit   <= 1'b1;
                if (lit)
                    idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (lit) begin
                control_pins <= ~(DIGITS'(1) << idx);
                display_pins <= seg_next;
            end
        end
    end
endmodule
